// File: rtl/period_avg_tracker.sv
// Period capture, range filter, lock tracking and 2^LOG2_AVG averaging of
// upstream period counts, with a valid/ready result port.
module period_avg_tracker #(
  parameter int unsigned W_N_MAX   = 16,
  parameter int unsigned LOG2_AVG  = 2,
  parameter int unsigned MIN_PER   = 4,
  parameter int unsigned MAX_PER   = 1000,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               clr,
  input  logic [W_N_MAX-1:0] count_in,
  input  logic               valid_in,
  output logic [W_N_MAX-1:0] avg_out,
  output logic               avg_valid,
  input  logic               avg_ready,
  output logic               locked,
  output logic [1:0]         state_o,
  output logic               overrun,
  output logic [7:0]         err_cnt
);

  localparam int unsigned ACC_W  = W_N_MAX + LOG2_AVG;
  localparam int unsigned NACC_W = LOG2_AVG + 1;
  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2, LOST = 2'd3} state_t;

  state_t              state, state_nxt;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [BAD_W-1:0]    bad_run, bad_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt, sum;
  logic [NACC_W-1:0]   nacc, nacc_nxt;
  logic                valid_q, cap_stb, good, res_vld;
  logic [W_N_MAX-1:0]  cap_val, res_val;

  assign state_o = state;

  // FSM and accumulator registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      run_cnt <= '0;
      bad_run <= '0;
      acc     <= '0;
      nacc    <= '0;
    end else if (clr) begin
      state   <= IDLE;
      run_cnt <= '0;
      bad_run <= '0;
      acc     <= '0;
      nacc    <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      bad_run <= bad_nxt;
      acc     <= acc_nxt;
      nacc    <= nacc_nxt;
    end
  end

  // Next-state logic; only a capture strobe moves the FSM
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    bad_nxt   = bad_run;
    acc_nxt   = acc;
    nacc_nxt  = nacc;
    res_vld   = 1'b0;
    good      = (cap_val >= W_N_MAX'(MIN_PER)) && (cap_val <= W_N_MAX'(MAX_PER));
    sum       = acc + ACC_W'(cap_val);
    res_val   = W_N_MAX'(sum >> LOG2_AVG);
    if (cap_stb) begin
      case (state)
        IDLE, LOST: begin
          if (good) begin
            state_nxt = ACQ;
            run_nxt   = RUN_W'(1);
          end
        end
        ACQ: begin
          if (good) begin
            run_nxt = run_cnt + RUN_W'(1);
            if (run_nxt == RUN_W'(LOCK_CNT)) begin
              state_nxt = TRACK;
              acc_nxt   = '0;
              nacc_nxt  = '0;
              bad_nxt   = '0;
            end
          end else begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end
        end
        TRACK: begin
          if (good) begin
            bad_nxt = '0;
            if (nacc == NACC_W'(2 ** LOG2_AVG - 1)) begin
              res_vld  = 1'b1;
              acc_nxt  = '0;
              nacc_nxt = '0;
            end else begin
              acc_nxt  = sum;
              nacc_nxt = nacc + NACC_W'(1);
            end
          end else begin
            bad_nxt = bad_run + BAD_W'(1);
            if (bad_nxt == BAD_W'(ERR_LIMIT)) begin
              state_nxt = LOST;
              acc_nxt   = '0;
              nacc_nxt  = '0;
              bad_nxt   = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Capture on valid_in rising edge; valid_q resets high to mask a level-high valid
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      valid_q   <= 1'b1;
      cap_stb   <= 1'b0;
      cap_val   <= '0;
      locked    <= 1'b0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
      err_cnt   <= '0;
    end else if (clr) begin
      valid_q   <= 1'b1;
      cap_stb   <= 1'b0;
      cap_val   <= '0;
      locked    <= 1'b0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      valid_q <= valid_in;
      cap_stb <= valid_in && !valid_q;
      if (valid_in && !valid_q) cap_val <= count_in;
      locked <= (state_nxt == TRACK);
      if (cap_stb && !good && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      // A same-cycle accept frees the slot for the new result
      if (res_vld) begin
        if (!avg_valid || avg_ready) begin
          avg_out   <= res_val;
          avg_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_avg_tracker.sv
// Bench for period_avg_tracker: directed scenarios plus random captures,
// checked against a capture-level model built on a sample window queue.
module tb_period_avg_tracker;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] count_in = '0;
  logic        valid_in = 1'b0;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        avg_ready = 1'b1;
  logic        locked;
  logic [1:0]  state_o;
  logic        overrun;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int m_state, m_run, m_bad, m_err;
  int m_out;
  bit m_valid, m_over;
  int win[$];

  period_avg_tracker dut (
    .clk(clk), .reset_l(reset_l), .clr(clr),
    .count_in(count_in), .valid_in(valid_in),
    .avg_out(avg_out), .avg_valid(avg_valid), .avg_ready(avg_ready),
    .locked(locked), .state_o(state_o), .overrun(overrun), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_bad = 0; m_err = 0;
    m_out = 0; m_valid = 0; m_over = 0;
    win.delete();
  endtask

  // One clock with no new result: only the output handshake can move
  task automatic model_idle();
    if (m_valid && avg_ready) m_valid = 0;
  endtask

  task automatic model_capture(input int v);
    bit good;
    bit fresh;
    int res;
    int s;
    good  = (v >= 4) && (v <= 1000);
    fresh = 0;
    res   = 0;
    if (!good && m_err < 255) m_err++;
    case (m_state)
      0, 3: if (good) begin m_state = 1; m_run = 1; end
      1: begin
        if (good) begin
          m_run++;
          if (m_run == 4) begin m_state = 2; win.delete(); m_bad = 0; end
        end else begin
          m_state = 0; m_run = 0;
        end
      end
      default: begin
        if (good) begin
          m_bad = 0;
          win.push_back(v);
          if (win.size() == 4) begin
            s = 0;
            foreach (win[i]) s += win[i];
            res = (s / 4) % 65536;
            fresh = 1;
            win.delete();
          end
        end else begin
          m_bad++;
          if (m_bad == 3) begin m_state = 3; m_bad = 0; win.delete(); end
        end
      end
    endcase
    if (fresh) begin
      if (!m_valid || avg_ready) begin m_out = res; m_valid = 1; end
      else m_over = 1;
    end else begin
      model_idle();
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state_o), 32'(m_state));
    chk({tag, ".locked"}, 32'(locked), 32'(m_state == 2));
    chk({tag, ".avg_valid"}, 32'(avg_valid), 32'(m_valid));
    chk({tag, ".avg_out"}, 32'(avg_out), 32'(m_out));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_over));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
  endtask

  task automatic idle();
    @(negedge clk);
    model_idle();
  endtask

  // Rising edge on valid_in carrying v, held high for hold cycles; rdy >= 0
  // sets avg_ready for the clock on which the capture is processed.
  task automatic cap(input int v, input int hold, input int rdy, input string tag);
    count_in = 16'(v);
    valid_in = 1'b1;
    idle();
    for (int i = 0; i < hold; i++) begin
      if (i == hold - 1) valid_in = 1'b0;
      count_in = 16'($urandom);
      if (i == 0 && rdy >= 0) avg_ready = rdy[0];
      @(negedge clk);
      if (i == 0) model_capture(v);
      else model_idle();
    end
    check_all(tag);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    model_reset();
    clr = 1'b0;
    idle();
  endtask

  int bad_v;

  initial begin
    model_reset();
    valid_in = 1'b1;
    count_in = 16'd7;
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    repeat (3) idle();
    valid_in = 1'b0;
    idle();
    check_all("reset");

    for (int i = 0; i < 4; i++) cap(100, 1, -1, "lock");
    cap(100, 1, 1, "avg_a");
    cap(102, 1, -1, "avg_b");
    cap(98, 1, -1, "avg_c");
    cap(104, 1, -1, "avg_d");
    chk("avg101", 32'(avg_out), 32'd101);
    idle();
    check_all("avg_pulse");

    cap(100, 1, -1, "tr0");
    cap(5000, 1, -1, "tr1");
    for (int i = 0; i < 3; i++) cap(100, 1, -1, "tr2");
    cap(2000, 1, -1, "lost0");
    cap(2, 1, -1, "lost1");
    cap(2000, 1, -1, "lost2");
    chk("lost_state", 32'(state_o), 32'd3);
    for (int i = 0; i < 4; i++) cap(50, 1, -1, "reacq");

    avg_ready = 1'b0;
    for (int i = 0; i < 4; i++) cap(200, 1, -1, "ov200");
    for (int i = 0; i < 4; i++) cap(300, 1, -1, "ov300");
    chk("ov_hold", 32'(avg_out), 32'd200);
    avg_ready = 1'b1;
    idle();
    check_all("ov_drain");
    do_clr();
    check_all("clr");

    for (int i = 0; i < 4; i++) cap(40, 1, -1, "lock2");
    avg_ready = 1'b0;
    for (int i = 0; i < 4; i++) cap(32, 1, -1, "p32");
    for (int i = 0; i < 3; i++) cap(64, 1, -1, "p64");
    cap(64, 1, 1, "same_cycle");
    chk("sc_out", 32'(avg_out), 32'd64);
    idle();
    check_all("sc_drain");

    // Range boundaries
    cap(4, 1, -1, "bnd4");
    cap(1000, 1, -1, "bnd1000");
    cap(3, 1, -1, "bnd3");
    cap(1001, 1, -1, "bnd1001");

    cap(333, 10, -1, "hold");

    for (int n = 0; n < 200; n++) begin
      avg_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) cap(int'($urandom_range(4, 1000)), 1, -1, "rand");
      else if ($urandom_range(0, 1) == 1) cap(int'($urandom_range(0, 3)), 1, -1, "rand");
      else cap(int'($urandom_range(1001, 65535)), int'($urandom_range(1, 3)), -1, "rand");
    end

    for (int n = 0; n < 300; n++) begin
      bad_v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(1001, 65535));
      cap(bad_v, 1, -1, "sat");
    end
    chk("err_sat", 32'(err_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
